// File: rtl/ntt_stride_permute.sv
// Streaming reorder stage between NTT butterfly stages: buffers one frame per
// bank (ping-pong) and re-emits it as (lo(j), lo(j)+STRIDE) pairs.
module ntt_stride_permute #(
    parameter int unsigned N      = 1024,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned WIDTH  = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    output logic             out_last,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned JW = AW - 1;
    localparam int unsigned SB = $clog2(STRIDE);
    localparam logic [JW-1:0] J_LAST = '1;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    logic [WIDTH-1:0] mem [2][N];

    logic [JW-1:0]    wr_cnt;
    logic             wr_bank;
    logic [1:0]       full;
    logic [1:0]       full_next;

    rd_state_t        state;
    logic             rd_bank;
    logic [JW-1:0]    rd_j;
    logic [AW-1:0]    rd_lo;
    logic [AW-1:0]    rd_hi;

    logic             wr_finish;
    logic             rd_issue;
    logic             rd_end;

    logic             s1_valid;
    logic             s1_last;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;

    // lo(j): insert a zero at bit position log2(STRIDE) of j.
    function automatic logic [AW-1:0] lo_addr(input logic [JW-1:0] j);
        logic [AW-1:0] jj;
        jj = AW'(j);
        return ((jj >> SB) << (SB + 1)) | (jj & AW'(STRIDE - 1));
    endfunction

    assign wr_finish = in_valid && (wr_cnt == J_LAST);
    // Banks fill and drain in the same order, so in IDLE the next full bank is rd_bank;
    // issuing j=0 straight from IDLE keeps the two-cycle first-pair latency.
    assign rd_issue  = (state == READ) || full[rd_bank];
    assign rd_end    = rd_issue && (rd_j == J_LAST);
    assign rd_lo     = lo_addr(rd_j);
    assign rd_hi     = rd_lo | AW'(STRIDE);

    always_comb begin
        full_next = full;
        if (wr_finish)
            full_next[wr_bank] = 1'b1;
        if (rd_end)
            full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            mem[wr_bank][{wr_cnt, 1'b0}] <= x_in;
            mem[wr_bank][{wr_cnt, 1'b1}] <= y_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            full      <= '0;
            state     <= IDLE;
            rd_bank   <= 1'b0;
            rd_j      <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            full <= full_next;

            if (in_valid) begin
                if (wr_finish) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                end
            end

            s1_valid <= rd_issue;
            s1_last  <= rd_end;
            if (rd_issue) begin
                s1_x <= mem[rd_bank][rd_lo];
                s1_y <= mem[rd_bank][rd_hi];
                if (rd_end) begin
                    rd_j    <= '0;
                    rd_bank <= ~rd_bank;
                    // The other bank may complete on this very edge; chain without a bubble.
                    state   <= (full[~rd_bank] || wr_finish) ? READ : IDLE;
                end else begin
                    rd_j  <= rd_j + 1'b1;
                    state <= READ;
                end
            end

            out_valid <= s1_valid;
            out_last  <= s1_last;
            if (s1_valid) begin
                x_out <= s1_x;
                y_out <= s1_y;
            end
        end
    end

endmodule

// File: tb/tb_ntt_stride_permute.sv
// Directed bench: four N=16 instances (STRIDE 1,2,4,8) share one input stream;
// each output stream is checked against hand-computed pairing tables.
module tb_ntt_stride_permute;

    localparam int unsigned N = 16;
    localparam int unsigned W = 28;

    typedef struct {
        int x;
        int y;
        bit last;
        int c;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [3:0]   ov;
    logic [3:0]   ol;
    logic [W-1:0] xo [4];
    logic [W-1:0] yo [4];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_edge = 0;
    int e1;

    pair_t capq [4][$];

    // lo(j) for j = 0..7, STRIDE = 1, 2, 4, 8 (row index = log2 STRIDE)
    int lo_tab [4][8] = '{
        '{0, 2, 4, 6, 8, 10, 12, 14},
        '{0, 1, 4, 5, 8, 9, 12, 13},
        '{0, 1, 2, 3, 8, 9, 10, 11},
        '{0, 1, 2, 3, 4, 5, 6, 7}
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ntt_stride_permute #(
            .N(N),
            .STRIDE(1 << g),
            .WIDTH(W)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid),
            .x_in(x_in),
            .y_in(y_in),
            .out_valid(ov[g]),
            .out_last(ol[g]),
            .x_out(xo[g]),
            .y_out(yo[g])
        );

        always @(posedge clk)
            if (!rst && in_valid)
                assert (!u_dut.full[u_dut.wr_bank])
                else $error("write into full bank, stride %0d", 1 << g);
    end

    always @(negedge clk)
        for (int i = 0; i < 4; i++)
            if (ov[i] === 1'b1)
                capq[i].push_back('{int'(xo[i]), int'(yo[i]), ol[i], cyc});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_beats(input int base, input int first, input int cnt, input int gap);
        for (int k = first; k < first + cnt; k++) begin
            if (k != first)
                repeat (gap) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            @(negedge clk);
            in_valid = 1'b1;
            x_in = W'(base + 2 * k);
            y_in = W'(base + 2 * k + 1);
        end
        @(posedge clk);
        #1;
        last_edge = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic clear_caps();
        for (int i = 0; i < 4; i++)
            capq[i].delete();
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_s%0d_valid", tag, 1 << i), 32'(ov[i]), 0);
            chk($sformatf("%s_s%0d_last", tag, 1 << i), 32'(ol[i]), 0);
            chk($sformatf("%s_s%0d_x", tag, 1 << i), 32'(xo[i]), 0);
            chk($sformatf("%s_s%0d_y", tag, 1 << i), 32'(yo[i]), 0);
        end
    endtask

    task automatic verify(input string tag, input int nfr, input int b0, input int b1, input int first);
        int j;
        int base;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_s%0d_count", tag, 1 << i), capq[i].size(), nfr * 8);
            for (int p = 0; p < capq[i].size() && p < nfr * 8; p++) begin
                j = p % 8;
                base = (p < 8) ? b0 : b1;
                chk($sformatf("%s_s%0d_x%0d", tag, 1 << i, p), capq[i][p].x, base + lo_tab[i][j]);
                chk($sformatf("%s_s%0d_y%0d", tag, 1 << i, p), capq[i][p].y,
                    base + lo_tab[i][j] + (1 << i));
                chk($sformatf("%s_s%0d_last%0d", tag, 1 << i, p), 32'(capq[i][p].last), 32'(j == 7));
                chk($sformatf("%s_s%0d_cyc%0d", tag, 1 << i, p), capq[i][p].c, first + p);
            end
        end
        clear_caps();
    endtask

    initial begin
        // reset state
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        clear_caps();

        // single contiguous frame
        drive_beats(0, 0, 8, 0);
        e1 = last_edge;
        idle(14);
        verify("single", 1, 0, 0, e1 + 2);

        // back-to-back frames, second chained on the same edge the first drains
        drive_beats(0, 0, 8, 0);
        e1 = last_edge;
        drive_beats(100, 0, 8, 0);
        idle(16);
        verify("b2b", 2, 0, 100, e1 + 2);

        // gapped input: 1,0,0,1,0,0...
        drive_beats(0, 0, 8, 2);
        e1 = last_edge;
        idle(14);
        verify("gaps", 1, 0, 0, e1 + 2);

        // reset after 5 beats of a frame
        drive_beats(900, 0, 5, 0);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero("rst_partial");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("partial_s%0d_none", 1 << i), capq[i].size(), 0);
        clear_caps();
        drive_beats(200, 0, 8, 0);
        e1 = last_edge;
        idle(14);
        verify("after_partial", 1, 200, 200, e1 + 2);

        // reset during read of frame 1 while frame 2 is half written
        drive_beats(300, 0, 8, 0);
        drive_beats(350, 0, 4, 0);
        chk("pre_rst_valid", 32'(ov), 32'hF);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero("rst_read");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_caps();
        drive_beats(500, 0, 8, 0);
        e1 = last_edge;
        idle(14);
        verify("after_read_rst", 1, 500, 500, e1 + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ntt_stride_permute.md
Name: ntt_stride_permute

Overview:
- Streaming reorder stage between consecutive butterfly stages of the pipelined NTT datapath.
- Consumes the (x, y) pair stream produced by one butterfly stage, one pair per valid beat.
- Re-pairs elements at distance STRIDE and emits the pairs the next butterfly stage expects.
- Uses ping-pong frame storage, so consecutive frames stream through without bubbles.

Parameters:
- N, 1024: transform length in elements. Power of two, ≥4.
- STRIDE, 1: output pairing distance. Power of two, 1..N/2.
- WIDTH, 28: coefficient width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  x_in/y_in carry a valid pair this cycle.
- x_in  input  WIDTH  element 2k of the current input frame, where k is the valid-beat index.
- y_in  input  WIDTH  element 2k+1 of the current input frame.
- out_valid  output  1  x_out/y_out carry a valid pair.
- out_last  output  1  high with the final pair (j = N/2-1) of an output frame.
- x_out  output  WIDTH  element lo(j).
- y_out  output  WIDTH  element lo(j)+STRIDE.

Behaviour:
- Reset is asynchronous, active-high. On reset: out_valid=0, out_last=0, x_out=0, y_out=0, write count=0, write bank=0, both banks marked empty, read side IDLE.
- Frame: N/2 valid input beats. Only beats with in_valid=1 are counted; gaps of any length are allowed mid-frame.
- Storage: two banks of N×WIDTH each. The write side fills one bank while the read side drains the other. Implementation needs two reads per cycle, so use split sub-banks or register arrays.
- Input beat k writes element 2k ← x_in and element 2k+1 ← y_in in the current write bank.
- After beat N/2-1: the write bank is marked full, the write bank toggles, and the write count returns to 0 in the same edge.
- Output index j = 0..N/2-1. lo(j) = (j / STRIDE)·2·STRIDE + (j mod STRIDE). Division and mod are by a power of two, so this reduces to bit manipulation: insert a 0 at bit position log2(STRIDE).
- STRIDE=1 is the identity: the output frame equals the input frame pair-for-pair.
- Read FSM states:
  - IDLE → READ when a full bank exists. Read starts on the cycle after the final write edge.
  - READ: issue one read address pair per cycle, j = 0..N/2-1, contiguous with no gaps.
  - At j = N/2-1: mark the bank empty. If the other bank is already full, or becomes full on this same edge, continue READ with j=0 on the other bank with no bubble. Otherwise go to IDLE.
- Output timing: two-cycle read pipeline (registered memory read, then output register).
  - If the last input beat of a frame is sampled at edge E, pair j=0 appears with out_valid=1 after edge E+2.
  - Pairs j=1.. follow on consecutive cycles.
  - out_last is high only with j=N/2-1.
- Overflow is impossible: read rate is one pair per cycle, which is at least the write rate. The bench asserts that writing into a bank still marked full never occurs.
- Between frames with no pending bank, out_valid=0. x_out and y_out hold their last value; they are don't-care when out_valid=0 but are never X after reset.
- Reset mid-frame discards the partial input frame and any in-progress output immediately. out_valid drops asynchronously.
- No arithmetic is performed; data passes bit-exact.

Test Plan:
- N=16, STRIDE=1, one frame with elements e=0..15 (x_in=2k, y_in=2k+1, 8 contiguous beats) → 8 output pairs (0,1),(2,3)…(14,15). First out_valid appears 2 edges after the last input edge. out_last only on (14,15).
- N=16, STRIDE=4, same frame → pairs (0,4),(1,5),(2,6),(3,7),(8,12),(9,13),(10,14),(11,15).
- N=16, STRIDE=8, two back-to-back frames (second frame values +100) → 16 contiguous out_valid cycles with no bubble. The second frame starts (100,108) right after out_last on (7,15).
- N=16, STRIDE=2, input with in_valid toggling 1,0,0,1… (gaps) → output identical to the gapless run: (0,2),(1,3),(4,6)…. Output starts 2 edges after the 8th valid beat.
- Assert rst after 5 beats of a frame, then send a fresh full frame → no output for the partial frame. The fresh frame emerges intact. All outputs read 0 while rst is high.
- Assert rst during the READ of frame 1 while frame 2 is half written → out_valid drops immediately. The next complete frame after reset streams correctly.
